// File: rtl/act_sparse_writer.sv
// Sparse activation loader: drops zeros from a dense frame and writes
// {zero-run, value} entries to sequential RAM addresses starting at 0.
module act_sparse_writer #(
  parameter int VWIDTH   = 8,
  parameter int RWIDTH   = 4,
  parameter int DWIDTH   = RWIDTH + VWIDTH,
  parameter int AWIDTH   = 10,
  parameter int MEM_SIZE = 384,
  parameter int LWIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LWIDTH-1:0] frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VWIDTH-1:0] in_data,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_d,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] word_count,
  output logic              overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting activations, one per handshake
  // FIN   | last element taken; any final write is on the RAM port
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state, state_n;
  logic [LWIDTH-1:0] remaining;
  logic [RWIDTH-1:0] run;
  logic              hs;
  logic              need_write;
  logic              full;

  assign in_ready   = (state == RUN);
  assign busy       = (state != IDLE);
  assign hs         = in_valid & in_ready;
  // A zero only produces an entry when the run field is saturated (escape).
  assign need_write = hs & ((in_data != '0) | (run == '1));
  assign full       = (word_count == AWIDTH'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (frame_len == '0) ? FIN : RUN;
      RUN:  if (hs && remaining == LWIDTH'(1)) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      run        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      ram_addr   <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_d      <= '0;
      done       <= 1'b0;
    end else begin
      ram_ce <= 1'b0;
      ram_we <= 1'b0;
      done   <= (state == FIN);
      if (state == IDLE && start) begin
        remaining  <= frame_len;
        run        <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (hs) begin
        remaining <= remaining - 1'b1;
        if (need_write) run <= '0;
        else            run <= run + 1'b1;
        if (need_write) begin
          if (full) begin
            overflow <= 1'b1;
          end else begin
            ram_ce     <= 1'b1;
            ram_we     <= 1'b1;
            ram_addr   <= word_count;
            ram_d      <= {run, in_data};
            word_count <= word_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_act_sparse_writer.sv
// Directed bench for act_sparse_writer: table of frames with expected RAM
// writes, plus bubble, overflow (small RAM) and mid-frame reset sequences.
module tb_act_sparse_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, ram_ce, ram_we, busy, done, overflow;
  logic [9:0]  ram_addr, word_count;
  logic [11:0] ram_d;

  logic        in_ready_s, ram_ce_s, ram_we_s, busy_s, done_s, overflow_s;
  logic [9:0]  ram_addr_s, word_count_s;
  logic [11:0] ram_d_s;

  always #5 clk = ~clk;

  act_sparse_writer dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_d(ram_d),
    .busy(busy), .done(done), .word_count(word_count), .overflow(overflow)
  );

  act_sparse_writer #(.MEM_SIZE(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .ram_addr(ram_addr_s), .ram_ce(ram_ce_s), .ram_we(ram_we_s), .ram_d(ram_d_s),
    .busy(busy_s), .done(done_s), .word_count(word_count_s), .overflow(overflow_s)
  );

  typedef struct packed {
    logic [15:0]       len;
    logic [19:0][7:0]  data;
    logic [3:0]        nexp;
    logic [7:0][11:0]  exp_d;
    logic [9:0]        exp_wc;
  } vec_t;

  vec_t vecs[8];
  int   vectors = 0;
  int   miscompares = 0;
  int   cewe_err = 0;

  logic [9:0]  wa[$];
  logic [11:0] wd[$];
  logic [9:0]  sa[$];
  logic [11:0] sd[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin wa.push_back(ram_addr); wd.push_back(ram_d); end
    if (ram_we_s === 1'b1) begin sa.push_back(ram_addr_s); sd.push_back(ram_d_s); end
    if (ram_ce !== ram_we || ram_ce_s !== ram_we_s) cewe_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_queues();
    wa.delete(); wd.delete(); sa.delete(); sd.delete();
  endtask

  // Drives one frame and checks handshake/done timing on both instances.
  task automatic run_frame(input vec_t v, input bit gaps);
    @(posedge clk); #1;
    start = 1'b1; frame_len = v.len;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      if (gaps) begin
        int nb;
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          in_valid = 1'b0; in_data = 8'hAA;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; in_data = v.data[i];
      check("in_ready", {31'd0, in_ready}, 32'd1);
      check("in_ready_s", {31'd0, in_ready_s}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("fin_busy", {31'd0, busy}, 32'd1);
    check("fin_done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_s_pulse", {31'd0, done_s}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic check_writes(input vec_t v);
    check("nwrites", wa.size(), {28'd0, v.nexp});
    for (int i = 0; i < int'(v.nexp); i++) begin
      if (i < wa.size()) begin
        check("wr_addr", {22'd0, wa[i]}, i);
        check("wr_data", {20'd0, wd[i]}, {20'd0, v.exp_d[i]});
      end
    end
    check("word_count", {22'd0, word_count}, {22'd0, v.exp_wc});
    check("overflow", {31'd0, overflow}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_ram_addr"}, {22'd0, ram_addr}, 32'd0);
    check({tag, "_ram_ce"}, {31'd0, ram_ce}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_ram_d"}, {20'd0, ram_d}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_word_count"}, {22'd0, word_count}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int k = 0; k < 8; k++) vecs[k] = '0;
    // 5,0,0,7
    vecs[0].len = 4; vecs[0].data[0] = 8'd5; vecs[0].data[3] = 8'd7;
    vecs[0].nexp = 2; vecs[0].exp_d[0] = 12'h005; vecs[0].exp_d[1] = 12'h207; vecs[0].exp_wc = 2;
    // 17 zeros then 3
    vecs[1].len = 18; vecs[1].data[17] = 8'd3;
    vecs[1].nexp = 2; vecs[1].exp_d[0] = 12'hF00; vecs[1].exp_d[1] = 12'h103; vecs[1].exp_wc = 2;
    // 9,0,0: trailing zeros not written
    vecs[2].len = 3; vecs[2].data[0] = 8'd9;
    vecs[2].nexp = 1; vecs[2].exp_d[0] = 12'h009; vecs[2].exp_wc = 1;
    // six ones (overflows the MEM_SIZE=4 instance)
    vecs[3].len = 6;
    for (int k = 0; k < 6; k++) begin vecs[3].data[k] = 8'd1; vecs[3].exp_d[k] = 12'h001; end
    vecs[3].nexp = 6; vecs[3].exp_wc = 6;
    // 1,2,3,4
    vecs[4].len = 4;
    for (int k = 0; k < 4; k++) begin vecs[4].data[k] = 8'(k + 1); vecs[4].exp_d[k] = 12'(k + 1); end
    vecs[4].nexp = 4; vecs[4].exp_wc = 4;
    // 0,0,0,0,8
    vecs[5].len = 5; vecs[5].data[4] = 8'd8;
    vecs[5].nexp = 1; vecs[5].exp_d[0] = 12'h408; vecs[5].exp_wc = 1;
    // exactly 16 zeros: escape on the last one
    vecs[6].len = 16;
    vecs[6].nexp = 1; vecs[6].exp_d[0] = 12'hF00; vecs[6].exp_wc = 1;
    // empty frame
    vecs[7].len = 0; vecs[7].nexp = 0; vecs[7].exp_wc = 0;

    rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      clear_queues();
      run_frame(vecs[i], 1'b0);
      check_writes(vecs[i]);
      if (i == 3) begin
        check("small_nwrites", sa.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
          if (k < sa.size()) begin
            check("small_addr", {22'd0, sa[k]}, k);
            check("small_data", {20'd0, sd[k]}, 32'h001);
          end
        end
        check("small_word_count", {22'd0, word_count_s}, 32'd4);
        check("small_overflow", {31'd0, overflow_s}, 32'd1);
      end
    end

    // Bubbles in in_valid must not change the result.
    for (int r = 0; r < 2; r++) begin
      clear_queues();
      run_frame(vecs[0], 1'b1);
      check_writes(vecs[0]);
    end

    // Mid-frame reset after two of four handshakes.
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'd5;
    @(posedge clk); #1;
    in_data = 8'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_writes", wa.size(), 32'd0);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);

    v = '0;
    v.len = 1; v.data[0] = 8'd4; v.nexp = 1; v.exp_d[0] = 12'h004; v.exp_wc = 1;
    clear_queues();
    run_frame(v, 1'b0);
    check_writes(v);

    check("ce_without_we", cewe_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
